// File: rtl/collision_pkg.sv
// Shared constants for the blue character's collision detector and its movement consumer.
// Holds playfield geometry, collision_state bit meanings and the scan FSM encoding.
package collision_pkg;

  localparam int TILE_SHIFT = 4;
  localparam int MAP_COLS   = 40;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int MAP_DEPTH  = 1200;

  // collision_state bit positions; probe pair k>>1 lands on exactly these indices
  localparam int COL_GROUND = 0;
  localparam int COL_CEIL   = 1;
  localparam int COL_RIGHT  = 2;
  localparam int COL_LEFT   = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/collision_blue_if.sv
// Request/result and tile-ROM signals of the collision detector.
// slave is the detector's view; master is the frame logic plus ROM side.
interface collision_blue_if;

  logic        start;
  logic [9:0]  current_x;
  logic [8:0]  current_y;
  logic [10:0] map_addr;
  logic        map_data;
  logic        busy;
  logic        done;
  logic [3:0]  collision_state;

  modport slave (
    input  start, current_x, current_y, map_data,
    output map_addr, busy, done, collision_state
  );

  modport master (
    output start, current_x, current_y, map_data,
    input  map_addr, busy, done, collision_state
  );

endinterface

// File: rtl/collision_probe_addr.sv
// Maps latched position and probe index to a tile ROM address and an off-screen flag.
// Purely combinational; off-screen probes still yield a (don't-care) address.
module collision_probe_addr
  import collision_pkg::*;
#(
  parameter int CHAR_W = 16,
  parameter int CHAR_H = 16
) (
  input  logic [9:0]  i_x,
  input  logic [8:0]  i_y,
  input  logic [2:0]  i_idx,
  output logic [10:0] o_map_addr,
  output logic        o_offscreen
);

  logic [10:0]             w_px;
  logic [9:0]              w_py;
  logic                    w_under;
  logic [9-TILE_SHIFT:0]   w_row;
  logic [10-TILE_SHIFT:0]  w_col;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_px    = {1'b0, i_x};
    w_py    = {1'b0, i_y};
    w_under = 1'b0;
    case (i_idx)
      3'd0: w_py = {1'b0, i_y} + 10'(CHAR_H);
      3'd1: begin
        w_px = {1'b0, i_x} + 11'(CHAR_W - 1);
        w_py = {1'b0, i_y} + 10'(CHAR_H);
      end
      3'd2: begin
        w_py    = {1'b0, i_y} - 10'd1;
        w_under = (i_y == 9'd0);
      end
      3'd3: begin
        w_px    = {1'b0, i_x} + 11'(CHAR_W - 1);
        w_py    = {1'b0, i_y} - 10'd1;
        w_under = (i_y == 9'd0);
      end
      3'd4: w_px = {1'b0, i_x} + 11'(CHAR_W);
      3'd5: begin
        w_px = {1'b0, i_x} + 11'(CHAR_W);
        w_py = {1'b0, i_y} + 10'(CHAR_H - 1);
      end
      3'd6: begin
        w_px    = {1'b0, i_x} - 11'd1;
        w_under = (i_x == 10'd0);
      end
      3'd7: begin
        w_px    = {1'b0, i_x} - 11'd1;
        w_py    = {1'b0, i_y} + 10'(CHAR_H - 1);
        w_under = (i_x == 10'd0);
      end
      default: ;
    endcase
  end

  assign w_row = w_py[9:TILE_SHIFT];
  assign w_col = w_px[10:TILE_SHIFT];

  assign o_map_addr  = 11'(w_row) * 11'(MAP_COLS) + 11'(w_col);
  assign o_offscreen = w_under || (w_px >= 11'(SCREEN_W)) || (w_py >= 10'(SCREEN_H));

endmodule

// File: rtl/collision_blue.sv
// Per-frame collision detector for the blue character: eight ROM probes around the
// character box, one per cycle, folded into a 4-bit collision_state with a done pulse.
module collision_blue
  import collision_pkg::*;
#(
  parameter int CHAR_W = 16,
  parameter int CHAR_H = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  collision_blue_if.slave  bus
);

  logic [1:0]  r_state;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic [2:0]  r_probe;
  logic        r_pend;
  logic [1:0]  r_pend_bit;
  logic        r_pend_off;
  logic [3:0]  r_acc;
  logic [3:0]  r_collision;
  logic        r_done;
  logic        r_busy;
  logic [10:0] w_addr;
  logic        w_off;

  collision_probe_addr #(
    .CHAR_W (CHAR_W),
    .CHAR_H (CHAR_H)
  ) u_probe_addr (
    .i_x         (r_x),
    .i_y         (r_y),
    .i_idx       (r_probe),
    .o_map_addr  (w_addr),
    .o_offscreen (w_off)
  );

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_probe     <= '0;
      r_pend      <= 1'b0;
      r_pend_bit  <= '0;
      r_pend_off  <= 1'b0;
      r_acc       <= '0;
      r_collision <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_pend <= 1'b0;
      // ROM data for the probe issued last cycle arrives now; off-screen overrides it
      if (r_pend) begin
        r_acc[r_pend_bit] <= r_acc[r_pend_bit] | r_pend_off | bus.map_data;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_x     <= bus.current_x;
            r_y     <= bus.current_y;
            r_probe <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_pend     <= 1'b1;
          r_pend_bit <= r_probe[2:1];
          r_pend_off <= w_off;
          r_probe    <= r_probe + 3'd1;
          if (r_probe == 3'd7) r_state <= ST_DRAIN;
        end
        ST_DRAIN: r_state <= ST_DONE;
        ST_DONE: begin
          r_collision <= r_acc;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.map_addr        = (r_state == ST_ISSUE) ? w_addr : '0;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.collision_state = r_collision;

endmodule

// File: tb/tb_collision_blue.sv
// Directed self-checking bench for collision_blue with a registered tile ROM model.
module tb_collision_blue;
  import collision_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  logic rom [0:MAP_DEPTH-1];

  collision_blue_if bus ();

  collision_blue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one-cycle ROM latency
  always @(posedge clk) begin
    if (bus.map_addr < 11'(MAP_DEPTH)) bus.map_data <= rom[bus.map_addr];
    else                               bus.map_data <= 1'b0;
  end

  task automatic clear_map();
    for (int i = 0; i < MAP_DEPTH; i++) rom[i] = 1'b0;
  endtask

  task automatic do_start(input logic [9:0] x, input logic [8:0] y);
    @(negedge clk);
    bus.current_x = x;
    bus.current_y = y;
    bus.start     = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // returns edges after the accept edge at which done was seen, or -1 on timeout
  task automatic wait_done(input int elapsed, output int n);
    n = elapsed;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done === 1'b1) return;
    end
    n = -1;
  endtask

  task automatic test_reset();
    int n_done;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.current_x = '0;
    bus.current_y = '0;
    bus.map_data = 1'b0;
    clear_map();
    repeat (2) @(posedge clk);
    #2;
    n_total++;
    if (bus.collision_state !== 4'b0000) $display("FAIL reset_state: got %b expected 0000", bus.collision_state);
    else n_pass++;
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy);
    else n_pass++;
    n_total++;
    if (bus.map_addr !== 11'd0) $display("FAIL reset_addr: got %0d expected 0", bus.map_addr);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) n_done++;
    end
    n_total++;
    if (n_done != 0) $display("FAIL idle_quiet: got %0d active cycles expected 0", n_done);
    else n_pass++;
  endtask

  task automatic test_ground();
    int n;
    clear_map();
    rom[20*40 + 10] = 1'b1;
    do_start(10'd160, 9'd304);
    wait_done(0, n);
    n_total++;
    if (n != 10) $display("FAIL ground_latency: got %0d expected 10", n);
    else n_pass++;
    n_total++;
    if (bus.collision_state !== 4'b0001) $display("FAIL ground_state: got %b expected 0001", bus.collision_state);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL ground_busy_at_done: got %b expected 0", bus.busy);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL ground_done_width: got %b expected 0", bus.done);
    else n_pass++;
    n_total++;
    if (bus.collision_state !== 4'b0001) $display("FAIL ground_hold: got %b expected 0001", bus.collision_state);
    else n_pass++;
  endtask

  task automatic test_left_edge();
    int n;
    logic [10:0] addrs [0:7];
    logic [10:0] exp_addrs [0:5];
    logic busy_mid;
    exp_addrs = '{11'd520, 11'd520, 11'd480, 11'd480, 11'd481, 11'd521};
    clear_map();
    do_start(10'd0, 9'd200);
    for (int k = 0; k < 8; k++) begin
      addrs[k] = bus.map_addr;
      if (k == 3) busy_mid = bus.busy;
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 6; k++) begin
      n_total++;
      if (addrs[k] !== exp_addrs[k]) $display("FAIL left_addr%0d: got %0d expected %0d", k, addrs[k], exp_addrs[k]);
      else n_pass++;
    end
    n_total++;
    if (busy_mid !== 1'b1) $display("FAIL left_busy_mid: got %b expected 1", busy_mid);
    else n_pass++;
    wait_done(8, n);
    n_total++;
    if (n != 10) $display("FAIL left_latency: got %0d expected 10", n);
    else n_pass++;
    n_total++;
    if (bus.collision_state !== 4'b1000) $display("FAIL left_state: got %b expected 1000", bus.collision_state);
    else n_pass++;
  endtask

  task automatic test_ceil_right();
    int n;
    clear_map();
    rom[9*40 + 20]  = 1'b1;
    rom[10*40 + 21] = 1'b1;
    do_start(10'd320, 9'd160);
    wait_done(0, n);
    n_total++;
    if (n != 10) $display("FAIL ceil_right_latency: got %0d expected 10", n);
    else n_pass++;
    n_total++;
    if (bus.collision_state !== 4'b0110) $display("FAIL ceil_right_state: got %b expected 0110", bus.collision_state);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int n;
    int n_done;
    logic done_at10;
    clear_map();
    rom[20*40 + 10] = 1'b1;
    do_start(10'd160, 9'd304);
    n_done = 0;
    done_at10 = 1'b0;
    // extra starts before edge T+3 (busy) and T+10 (DONE cycle) must both be dropped
    for (int c = 1; c <= 10; c++) begin
      if (c == 3 || c == 10) begin
        bus.current_x = 10'd0;
        bus.current_y = 9'd200;
        bus.start     = 1'b1;
      end
      @(posedge clk);
      #1 bus.start = 1'b0;
      if (bus.done === 1'b1) n_done++;
      if (c == 10) done_at10 = bus.done;
    end
    n_total++;
    if (done_at10 !== 1'b1) $display("FAIL busy_done_at_t10: got %b expected 1", done_at10);
    else n_pass++;
    n_total++;
    if (n_done != 1) $display("FAIL busy_done_count: got %0d expected 1", n_done);
    else n_pass++;
    n_total++;
    if (bus.collision_state !== 4'b0001) $display("FAIL busy_state: got %b expected 0001", bus.collision_state);
    else n_pass++;
    bus.current_x = 10'd0;
    bus.current_y = 9'd200;
    bus.start     = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(0, n);
    n_total++;
    if (n != 10) $display("FAIL rearm_latency: got %0d expected 10", n);
    else n_pass++;
    n_total++;
    if (bus.collision_state !== 4'b1000) $display("FAIL rearm_state: got %b expected 1000", bus.collision_state);
    else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    int n_done;
    clear_map();
    do_start(10'd0, 9'd200);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", bus.busy);
    else n_pass++;
    n_total++;
    if (bus.collision_state !== 4'b0000) $display("FAIL abort_state: got %b expected 0000", bus.collision_state);
    else n_pass++;
    n_total++;
    if (bus.map_addr !== 11'd0) $display("FAIL abort_addr: got %0d expected 0", bus.map_addr);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) n_done++;
    end
    n_total++;
    if (n_done != 0) $display("FAIL abort_no_done: got %0d pulses expected 0", n_done);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_ground();
    test_left_edge();
    test_ceil_right();
    test_start_while_busy();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
